csr_irq_ctrl: RTL
=================

Name: csr_irq_ctrl

Overview:
- Parametrised machine-mode CSR file and interrupt controller for the 5-stage RV32 core; successor to the single-source CSR block.
- Supports NUM_IRQ level-sensitive external interrupt lines with fixed priority, and mcause.
- mtvec supports direct and vectored modes. A WFI sleep FSM and instruction-retire counting are included.
- Sits beside EX; drives the fetch-redirect and stall signals.

Parameters:
- XLEN, 32, data and address width.
- NUM_IRQ, 4, external interrupt lines (1..16), mapped to mip/mie bits 16+i.
- MTVEC_RST, 32'h0001_0000, mtvec reset value.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ex_en  in  1  EX stage advancing this cycle
- ex_pc  in  XLEN  PC of the instruction in EX
- csr_addr  in  12  CSR address
- csr_op  in  2  00 none, 01 write, 10 set, 11 clear
- csr_wdata  in  XLEN  rs1 or zimm operand
- csr_rdata  out  XLEN  old CSR value (combinational)
- wfi_i  in  1  WFI in EX
- mret_i  in  1  MRET in EX
- retire_i  in  1  instruction retired this cycle
- irq_i  in  NUM_IRQ  external interrupt levels
- trap_o  out  1  take interrupt: flush and redirect (combinational)
- trap_pc_o  out  XLEN  handler PC
- mret_o  out  1  MRET redirect (combinational)
- ret_pc_o  out  XLEN  equals mepc
- stall_o  out  1  core sleeping in WFI (registered)

Behaviour:
- Reset values: mstatus=0, mie=0, mtvec=MTVEC_RST, mepc=0, mcause=0, counters=0, FSM=RUN, stall_o=0.
- Addresses:
  - mstatus 300: only MIE[3], MPIE[7], MPP[12:11] stored.
  - mie 304: bits 16+i writable.
  - mtvec 305: bit1 reads 0.
  - mepc 341: bits[1:0] read 0.
  - mcause 342.
  - mip 344: read-only; bit 16+i = irq_s[i].
  - mcycle B00, mcycleh B80, minstret B02, minstreth B82: read-only.
  - Any other address reads 0; writes to it are ignored.
- irq_s: irq_i as used internally (see Optional Feature). pend = irq_s & mie[16+NUM_IRQ-1:16].
- Winning source: lowest set index k of pend; cause = 16+k.
- CSR update happens only when ex_en=1 and csr_op!=00.
  - new = wdata (write), old|wdata (set), old&~wdata (clear).
  - Set or clear with wdata=0 leaves the register unchanged.
- Priority within one ex_en cycle: trap > mret > wfi > csr op.
  - The lower-priority actions are suppressed for that cycle.
- FSM RUN:
  - Trap condition: ex_en & mstatus.MIE & |pend.
  - On trap, trap_o=1 that cycle. At the edge: mepc<=ex_pc, mcause<={1'b1,cause}, MPIE<=MIE, MIE<=0, MPP<=11.
  - The EX instruction is not executed.
  - mret_i & ex_en: mret_o=1. At the edge: MIE<=MPIE, MPIE<=1, MPP<=11.
  - wfi_i & ex_en with no trap: save wpc=ex_pc+4 and go to SLEEP. stall_o=1 from the next cycle.
- FSM SLEEP:
  - stall_o=1; ex_en is ignored.
  - If |pend: leave SLEEP and stall_o<=0.
    - If MIE=1: trap_o=1 that cycle and mepc<=wpc; otherwise resume at wpc.
  - If pend=0, stay in SLEEP.
  - WFI wakes only on enabled sources (mie bit set). WFI with mie=0 sleeps until reset.
- trap_pc_o:
  - mtvec[1:0]=00: {mtvec[XLEN-1:2],2'b00}.
  - mtvec[1:0]=01: base + 4*cause.
  - Mode values 1x behave as direct.
- Counters: 64-bit.
  - mcycle increments every cycle.
  - minstret increments when retire_i=1.
  - Both wrap at 2^64-1 -> 0.
- Reset mid-SLEEP or mid-trap returns all state to the reset values.

Optional Feature:
- IRQ_SYNC_EN defined: each irq_i bit passes through a 2-flop synchroniser (reset 0). Interrupt latency is +2 cycles.
- IRQ_SYNC_EN undefined: irq_s = irq_i directly.

Test Plan:
- Reset -> read 305 = 0x0001_0000, 300 = 0, 344 = 0; stall_o = 0.
- Write mie=0x0002_0000, set mstatus=0x8, ex_pc=0x120, irq_i=4'b0110 -> trap_o=1, trap_pc_o=0x0001_0000. Afterwards: mepc=0x120, mcause=0x8000_0011, mstatus=0x1880.
- Write mtvec=0x0000_2001, repeat the previous scenario -> trap_pc_o=0x2044. Simultaneous mret_i is ignored.
- mret with mstatus=0x1880 -> mret_o=1, ret_pc_o=mepc. mstatus becomes 0x1888.
- WFI at pc=0x200, MIE=0, mie bit16 set -> stall_o=1. Raise irq_i[0] -> stall_o=0, trap_o=0, resume at 0x204.
  - Same sequence with MIE=1 -> trap_o=1, mepc=0x204.
- Pulse retire_i for 5 cycles across 10 cycles -> minstret delta=5, mcycle delta=10.
  - Preload-free wrap check via force: mcycle 0xFFFF_FFFF increments to mcycleh+1, mcycle=0.

Source files
------------

// File: rtl/csr_irq_ctrl.sv
// Machine-mode CSR file, fixed-priority interrupt controller and WFI sleep FSM.
// Optional: define IRQ_SYNC_EN to pass each irq_i bit through a 2-flop synchroniser.
module csr_irq_ctrl #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     NUM_IRQ   = 4,
    parameter logic [XLEN-1:0] MTVEC_RST = 32'h0001_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_en,
    input  logic [XLEN-1:0]    ex_pc,
    input  logic [11:0]        csr_addr,
    input  logic [1:0]         csr_op,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    input  logic               wfi_i,
    input  logic               mret_i,
    input  logic               retire_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic               trap_o,
    output logic [XLEN-1:0]    trap_pc_o,
    output logic               mret_o,
    output logic [XLEN-1:0]    ret_pc_o,
    output logic               stall_o
);

    localparam logic [11:0] AddrMstatus   = 12'h300;
    localparam logic [11:0] AddrMie       = 12'h304;
    localparam logic [11:0] AddrMtvec     = 12'h305;
    localparam logic [11:0] AddrMepc      = 12'h341;
    localparam logic [11:0] AddrMcause    = 12'h342;
    localparam logic [11:0] AddrMip       = 12'h344;
    localparam logic [11:0] AddrMcycle    = 12'hB00;
    localparam logic [11:0] AddrMinstret  = 12'hB02;
    localparam logic [11:0] AddrMcycleh   = 12'hB80;
    localparam logic [11:0] AddrMinstreth = 12'hB82;

    typedef enum logic [0:0] {StRun, StSleep} state_e;

    state_e             state_q;
    logic               stall_q;
    logic               mstatus_mie_q;
    logic               mstatus_mpie_q;
    logic [1:0]         mstatus_mpp_q;
    logic [NUM_IRQ-1:0] mie_q;
    logic [XLEN-1:0]    mtvec_q;
    logic [XLEN-1:0]    mepc_q;
    logic [XLEN-1:0]    mcause_q;
    logic [XLEN-1:0]    wpc_q;
    logic [63:0]        mcycle_q;
    logic [63:0]        minstret_q;

    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] pend;
    logic               irq_any;
    logic [4:0]         cause;
    logic               trap_run;
    logic               trap_wake;
    logic               wfi_go;
    logic               csr_we;
    logic [XLEN-1:0]    mstatus_rd;
    logic [XLEN-1:0]    mie_rd;
    logic [XLEN-1:0]    mip_rd;
    logic [XLEN-1:0]    wr_val;
    logic [XLEN-1:0]    tvec_base;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] irq_sync1_q;
    logic [NUM_IRQ-1:0] irq_sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_sync1_q <= '0;
            irq_sync2_q <= '0;
        end else begin
            irq_sync1_q <= irq_i;
            irq_sync2_q <= irq_sync1_q;
        end
    end

    assign irq_s = irq_sync2_q;
`else
    assign irq_s = irq_i;
`endif

    assign pend    = irq_s & mie_q;
    assign irq_any = |pend;

    // Lowest pending index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        cause = 5'd16;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (pend[i]) begin
                cause = 5'd16 + 5'(i);
            end
        end
    end

    assign trap_run  = (state_q == StRun) && ex_en && mstatus_mie_q && irq_any;
    assign trap_wake = (state_q == StSleep) && mstatus_mie_q && irq_any;
    assign trap_o    = trap_run || trap_wake;
    assign mret_o    = (state_q == StRun) && ex_en && mret_i && !trap_run;
    assign wfi_go    = (state_q == StRun) && ex_en && wfi_i && !trap_run && !mret_i;
    assign csr_we    = (state_q == StRun) && ex_en && (csr_op != 2'b00)
                       && !trap_run && !mret_i && !wfi_i;

    // Mode 01 is vectored; 00 and 1x fall back to direct.
    assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_pc_o = (mtvec_q[1:0] == 2'b01) ? tvec_base + (XLEN'(cause) << 2) : tvec_base;
    assign ret_pc_o  = {mepc_q[XLEN-1:2], 2'b00};
    assign stall_o   = stall_q;

    always_comb begin
        mstatus_rd          = '0;
        mstatus_rd[3]       = mstatus_mie_q;
        mstatus_rd[7]       = mstatus_mpie_q;
        mstatus_rd[12:11]   = mstatus_mpp_q;
        mie_rd              = '0;
        mie_rd[16+:NUM_IRQ] = mie_q;
        mip_rd              = '0;
        mip_rd[16+:NUM_IRQ] = irq_s;
    end

    always_comb begin
        case (csr_addr)
            AddrMstatus:   csr_rdata = mstatus_rd;
            AddrMie:       csr_rdata = mie_rd;
            AddrMtvec:     csr_rdata = {mtvec_q[XLEN-1:2], 1'b0, mtvec_q[0]};
            AddrMepc:      csr_rdata = {mepc_q[XLEN-1:2], 2'b00};
            AddrMcause:    csr_rdata = mcause_q;
            AddrMip:       csr_rdata = mip_rd;
            AddrMcycle:    csr_rdata = XLEN'(mcycle_q[31:0]);
            AddrMcycleh:   csr_rdata = XLEN'(mcycle_q[63:32]);
            AddrMinstret:  csr_rdata = XLEN'(minstret_q[31:0]);
            AddrMinstreth: csr_rdata = XLEN'(minstret_q[63:32]);
            default:       csr_rdata = '0;
        endcase
    end

    always_comb begin
        case (csr_op)
            2'b01:   wr_val = csr_wdata;
            2'b10:   wr_val = csr_rdata | csr_wdata;
            2'b11:   wr_val = csr_rdata & ~csr_wdata;
            default: wr_val = csr_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StRun;
            stall_q        <= 1'b0;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mstatus_mpp_q  <= 2'b00;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RST;
            mepc_q         <= '0;
            mcause_q       <= '0;
            wpc_q          <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
        end else begin
            mcycle_q <= mcycle_q + 64'd1;
            if (retire_i) begin
                minstret_q <= minstret_q + 64'd1;
            end
            case (state_q)
                StRun: begin
                    if (trap_run) begin
                        mepc_q         <= ex_pc;
                        mcause_q       <= {1'b1, (XLEN-1)'(cause)};
                        mstatus_mpie_q <= mstatus_mie_q;
                        mstatus_mie_q  <= 1'b0;
                        mstatus_mpp_q  <= 2'b11;
                    end else if (mret_o) begin
                        mstatus_mie_q  <= mstatus_mpie_q;
                        mstatus_mpie_q <= 1'b1;
                        mstatus_mpp_q  <= 2'b11;
                    end else if (wfi_go) begin
                        wpc_q   <= ex_pc + XLEN'(3'd4);
                        state_q <= StSleep;
                        stall_q <= 1'b1;
                    end else if (csr_we) begin
                        case (csr_addr)
                            AddrMstatus: begin
                                mstatus_mie_q  <= wr_val[3];
                                mstatus_mpie_q <= wr_val[7];
                                mstatus_mpp_q  <= wr_val[12:11];
                            end
                            AddrMie:    mie_q    <= wr_val[16+:NUM_IRQ];
                            AddrMtvec:  mtvec_q  <= wr_val;
                            AddrMepc:   mepc_q   <= wr_val;
                            AddrMcause: mcause_q <= wr_val;
                            default: ;
                        endcase
                    end
                end
                StSleep: begin
                    // Only enabled sources wake the core; MIE decides trap vs. plain resume.
                    if (irq_any) begin
                        state_q <= StRun;
                        stall_q <= 1'b0;
                        if (mstatus_mie_q) begin
                            mepc_q         <= wpc_q;
                            mcause_q       <= {1'b1, (XLEN-1)'(cause)};
                            mstatus_mpie_q <= 1'b1;
                            mstatus_mie_q  <= 1'b0;
                            mstatus_mpp_q  <= 2'b11;
                        end
                    end
                end
                default: begin
                    state_q <= StRun;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
